regfile_wb_arbiter: RTL and testbench

Write-back port arbiter for the MIPS32 register file. It shares the single register-file write port between two write-back requesters (requester 0: ALU/main pipe, requester 1: load/multi-cycle unit) using a valid/ready handshake and fair round-robin arbitration. It presents one registered write per cycle to the register file's `RegWrite`/`WriteAddr`/`WriteData` inputs, and suppresses writes to register `$zero`.

---
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between two write-back
//   requesters with a valid/ready handshake and round-robin arbitration.
//   The winning write is registered and presented on RegWrite/WriteAddr/
//   WriteData for exactly one cycle. Writes to $zero complete the handshake
//   but never raise RegWrite.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/addr/data       requester N write request (N = 0, 1)
//   reqN_ready                 requester N accepted this cycle (combinational)
//   hold                       stall: no grant while high
//   RegWrite/WriteAddr/WriteData  registered write to the register file
//   prio                       requester that wins the next tie
//   wr_count                   committed non-zero-address writes (wraps)
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              hold,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0] WriteData,
  output logic              prio,
  output logic [CNT_W-1:0]  wr_count
);

  logic              prio_q,       prio_d;
  logic              reg_write_q,  reg_write_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [CNT_W-1:0]  wr_count_q,   wr_count_d;

  logic [1:0]        grant;
  logic              any_grant;
  logic              wr_en;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // One-hot grant. rst_n is folded in so both readies read 0 while reset
  // is asserted, even with requests pending.
  always_comb begin
    grant = 2'b00;
    if (rst_n && !hold) begin
      unique case ({req1_valid, req0_valid})
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign any_grant  = |grant;
  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign sel_data   = grant[1] ? req1_data : req0_data;
  // A granted write to $zero is consumed but never committed.
  assign wr_en      = any_grant && (sel_addr != '0);

  always_comb begin
    prio_d       = prio_q;
    reg_write_d  = wr_en;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    wr_count_d   = wr_count_q + {{(CNT_W-1){1'b0}}, wr_en};
    if (any_grant) begin
      // The loser of this grant wins the next tie: granted 0 -> prio 1.
      prio_d       = grant[0];
      write_addr_d = sel_addr;
      write_data_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= 1'b0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      wr_count_q   <= '0;
    end else begin
      prio_q       <= prio_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign WriteAddr = write_addr_q;
  assign WriteData = write_data_q;
  assign prio      = prio_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by random
// traffic. A reference model pushes every expected committed write into a
// scoreboard queue at the clock edge; a separate monitor pops and compares
// whenever the DUT presents RegWrite, and checks ready/prio each cycle.
module tb_regfile_wb_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
  logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
  logic              req0_ready, req1_ready;
  logic              hold = 1'b0;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
  logic              prio;
  logic [CNT_W-1:0]  wr_count;

  regfile_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .hold(hold), .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .prio(prio), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } req_t;
  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; logic [CNT_W-1:0] c; } exp_t;

  req_t src0[$], src1[$];   // pending requests per requester
  exp_t exp_q[$];           // scoreboard of expected committed writes

  int n_checks = 0;
  int n_fail   = 0;
  int tally    = 0;         // non-zero writes issued since the last reset

  logic             m_prio = 1'b0;
  logic [CNT_W-1:0] m_cnt  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arbitration rule stated directly: hold blocks, a lone requester wins,
  // a tie goes to the priority holder. Returns one-hot {g1, g0}.
  function automatic logic [1:0] grant_of(input logic v0, input logic v1, input logic h, input logic p);
    if (h) return 2'b00;
    if (v0 && v1) return p ? 2'b10 : 2'b01;
    if (v0) return 2'b01;
    if (v1) return 2'b10;
    return 2'b00;
  endfunction

  // Reference model: at each edge, decide the winner and record its write.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_prio = 1'b0;
      m_cnt  = '0;
      exp_q.delete();
    end else begin
      logic [1:0] g;
      exp_t e;
      g = grant_of(req0_valid, req1_valid, hold, m_prio);
      if (g != 2'b00) begin
        e.a = g[1] ? req1_addr : req0_addr;
        e.d = g[1] ? req1_data : req0_data;
        if (e.a != 0) begin
          m_cnt = m_cnt + 1'b1;
          e.c   = m_cnt;
          exp_q.push_back(e);
        end
        m_prio = (g == 2'b01);
      end
    end
  end

  // Monitor: away from the active edge, compare handshake and write port.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      logic [1:0] g;
      logic       exp_w;
      exp_t       e;
      g = grant_of(req0_valid, req1_valid, hold, m_prio);
      chk("req0_ready", {31'b0, req0_ready}, {31'b0, g[0]});
      chk("req1_ready", {31'b0, req1_ready}, {31'b0, g[1]});
      chk("prio", {31'b0, prio}, {31'b0, m_prio});
      exp_w = (exp_q.size() != 0);
      chk("reg_write", {31'b0, RegWrite}, {31'b0, exp_w});
      if (exp_w) begin
        e = exp_q.pop_front();
        if (RegWrite) begin
          chk("write_addr", {27'b0, WriteAddr}, {27'b0, e.a});
          chk("write_data", WriteData, e.d);
          chk("wr_count", {28'b0, wr_count}, {28'b0, e.c});
          $display("write addr=%0d data=%h wr_count=%0d", WriteAddr, WriteData, wr_count);
        end
      end
    end
  end

  // Requester driver: hold valid/addr/data until accepted at an edge.
  initial forever begin
    logic a0, a1;
    @(negedge clk);
    a0 = req0_ready;
    a1 = req1_ready;
    @(posedge clk);
    #1;
    if (a0 && rst_n && src0.size() != 0) void'(src0.pop_front());
    if (a1 && rst_n && src1.size() != 0) void'(src1.pop_front());
    req0_valid = (src0.size() != 0);
    if (req0_valid) begin req0_addr = src0[0].a; req0_data = src0[0].d; end
    req1_valid = (src1.size() != 0);
    if (req1_valid) begin req1_addr = src1[0].a; req1_data = src1[0].d; end
  end

  task automatic push0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_t r;
    r.a = a; r.d = d;
    src0.push_back(r);
    if (a != 0) tally++;
  endtask

  task automatic push1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_t r;
    r.a = a; r.d = d;
    src1.push_back(r);
    if (a != 0) tally++;
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_reg_write", {31'b0, RegWrite}, 32'd0);
    chk("rst_write_addr", {27'b0, WriteAddr}, 32'd0);
    chk("rst_write_data", WriteData, 32'd0);
    chk("rst_prio", {31'b0, prio}, 32'd0);
    chk("rst_wr_count", {28'b0, wr_count}, 32'd0);
    chk("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(1, 31));
  endfunction

  initial begin
    rst_n = 1'b0;
    #3;
    chk_reset_outputs();
    #10 rst_n = 1'b1;

    // Single requester
    wait_cycle();
    push1(5'd8, 32'hDEADBEEF);
    repeat (3) wait_cycle();

    // Contention: alternating grants
    push0(5'd1, 32'h0000_0001); push0(5'd2, 32'h0000_0002); push0(5'd3, 32'h0000_0003);
    push1(5'd9, 32'h0000_0009); push1(5'd10, 32'h0000_000A); push1(5'd11, 32'h0000_000B);
    repeat (8) wait_cycle();

    // $zero suppression
    push0(5'd0, 32'h12345678);
    repeat (2) wait_cycle();
    chk("zero_prio", {31'b0, prio}, 32'd1);
    chk("zero_wr_count", {28'b0, wr_count}, 32'd7);

    // Hold
    hold = 1'b1;
    push0(5'd5, 32'h5555_5555);
    repeat (3) wait_cycle();
    hold = 1'b0;
    repeat (3) wait_cycle();

    // Reset mid-stream while a write is registered
    push0(5'd6, 32'h6666_6666);
    push1(5'd7, 32'h7777_7777);
    for (int k = 0; k < 10; k++) begin
      wait_cycle();
      if (RegWrite) break;
    end
    chk("regwrite_before_reset", {31'b0, RegWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    tally = 0;
    foreach (src0[i]) if (src0[i].a != 0) tally++;
    foreach (src1[i]) if (src1[i].a != 0) tally++;
    #1 rst_n = 1'b1;
    push0(5'd3, 32'h0000_0333);
    push1(5'd4, 32'h0000_0444);
    repeat (6) wait_cycle();

    // Random traffic, including $zero targets and hold pulses
    for (int i = 0; i < 400; i++) begin
      wait_cycle();
      hold = ($urandom_range(0, 4) == 0);
      if (src0.size() < 2 && $urandom_range(0, 1) == 1) push0(rand_addr(), $urandom());
      if (src1.size() < 2 && $urandom_range(0, 1) == 1) push1(rand_addr(), $urandom());
    end

    // Drain
    hold = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (src0.size() == 0 && src1.size() == 0 && !req0_valid && !req1_valid) break;
      wait_cycle();
    end
    chk("drain_done", {31'b0, (src0.size() == 0 && src1.size() == 0)}, 32'd1);
    repeat (3) wait_cycle();
    chk("wr_count_total", {28'b0, wr_count}, 32'(tally % (1 << CNT_W)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
